// File: rtl/uart_viterbi_decoder.sv
// Byte-interfaced hard-decision Viterbi decoder (rate 1/2, register-exchange survivors).
// Four symbols per input byte, fixed decision delay D, decoded bits packed LSB-first.
module uart_viterbi_decoder #(
    parameter int         K      = 3,
    parameter logic [7:0] G0_OCT = 8'o7,
    parameter logic [7:0] G1_OCT = 8'o5,
    parameter int         D      = 16,
    parameter int         PM_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    input  logic       flush,
    output logic       flush_done
);
    localparam int M  = K - 1;
    localparam int NS = 1 << M;
    localparam int SW = PM_W + 2;
    localparam int CW = $clog2(D + 1);
    localparam int DW = $clog2(D);
    localparam logic [PM_W-1:0] PM_MAX  = {PM_W{1'b1}};
    localparam logic [PM_W-1:0] PM_INIT = PM_W'(2 * K);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_TAIL  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    function automatic logic parity_mask(input logic [K-1:0] r, input logic [K-1:0] g);
        return ^(r & g);
    endfunction

    function automatic logic [1:0] code_sym(input logic [K-1:0] r);
        return {parity_mask(r, G0_OCT[K-1:0]), parity_mask(r, G1_OCT[K-1:0])};
    endfunction

    function automatic logic [1:0] ham2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[0]} + {1'b0, x[1]};
    endfunction

    state_t          state_r, state_s;
    logic [7:0]      buf_r;
    logic [2:0]      left_r;
    logic [PM_W-1:0] pm_r   [NS];
    logic [D-1:0]    surv_r [NS];
    logic [CW-1:0]   sym_cnt_r, tail_r;
    logic [M-1:0]    best_r;
    logic [7:0]      pk_r;
    logic [2:0]      pk_cnt_r;
    logic [7:0]      out_byte_r;
    logic            out_valid_r, flush_done_r;

    logic [1:0]      sym_s;
    logic [SW-1:0]   cand_s      [NS];
    logic [M-1:0]    pred_s      [NS];
    logic [PM_W-1:0] pm_next_s   [NS];
    logic [D-1:0]    surv_next_s [NS];
    logic [SW-1:0]   min_s, m0_s, m1_s, diff_s;
    logic [M-1:0]    best_s, ns_s, p0_s, p1_s;
    logic            lt_s;
    logic            bit_due_s, pk_room_s, step_s, tail_fire_s, bit_valid_s, bit_s;
    logic            done_fire_s, pad_load_s, in_ready_s, accept_s;
    logic [DW-1:0]   tail_idx_s;

    // Add-compare-select, normalisation and best-state search for the current symbol
    always_comb begin
        sym_s  = buf_r[1:0];
        min_s  = {SW{1'b1}};
        best_s = '0;
        ns_s   = '0;
        p0_s   = '0;
        p1_s   = '0;
        m0_s   = '0;
        m1_s   = '0;
        diff_s = '0;
        lt_s   = 1'b0;
        for (int s = 0; s < NS; s++) begin
            cand_s[s]      = '0;
            pred_s[s]      = '0;
            pm_next_s[s]   = '0;
            surv_next_s[s] = '0;
        end
        for (int s = 0; s < NS; s++) begin
            ns_s = M'(s);
            p0_s = {ns_s[M-2:0], 1'b0};
            p1_s = {ns_s[M-2:0], 1'b1};
            m0_s = SW'(pm_r[p0_s]) + SW'(ham2(sym_s, code_sym({ns_s[M-1], p0_s})));
            m1_s = SW'(pm_r[p1_s]) + SW'(ham2(sym_s, code_sym({ns_s[M-1], p1_s})));
            cand_s[s] = (m0_s <= m1_s) ? m0_s : m1_s;
            pred_s[s] = (m0_s <= m1_s) ? p0_s : p1_s;
            lt_s   = (cand_s[s] < min_s);
            best_s = lt_s ? ns_s : best_s;
            min_s  = lt_s ? cand_s[s] : min_s;
        end
        for (int s = 0; s < NS; s++) begin
            ns_s   = M'(s);
            diff_s = cand_s[s] - min_s;
            pm_next_s[s]   = (diff_s > SW'(PM_MAX)) ? PM_MAX : diff_s[PM_W-1:0];
            surv_next_s[s] = {surv_r[pred_s[s]][D-2:0], ns_s[M-1]};
        end
    end

    // Datapath enables: step/stall, bit source, flush completion, input handshake
    always_comb begin
        bit_due_s   = (sym_cnt_r == CW'(D));
        pk_room_s   = !((pk_cnt_r == 3'd7) && out_valid_r && !out_ready);
        step_s      = ((state_r == S_RUN) || (state_r == S_FLUSH)) && (left_r != 3'd0)
                      && (!bit_due_s || pk_room_s);
        tail_fire_s = (state_r == S_TAIL) && (tail_r != '0) && pk_room_s;
        tail_idx_s  = DW'(tail_r - CW'(1));
        bit_valid_s = (step_s && bit_due_s) || tail_fire_s;
        // The streamed bit is the one the best path shifts out of its predecessor's survivor
        bit_s       = tail_fire_s ? surv_r[best_r][tail_idx_s] : surv_r[pred_s[best_s]][D-1];
        done_fire_s = (state_r == S_DONE) && ((pk_cnt_r == 3'd0) || !out_valid_r || out_ready);
        pad_load_s  = done_fire_s && (pk_cnt_r != 3'd0);
        in_ready_s  = (state_r == S_RUN) && ((left_r == 3'd0) || ((left_r == 3'd1) && step_s));
        accept_s    = in_valid && in_ready_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_INIT:  state_s = S_RUN;
            S_RUN:   state_s = flush ? S_FLUSH : S_RUN;
            S_FLUSH: state_s = (left_r == 3'd0) ? S_TAIL : S_FLUSH;
            S_TAIL:  state_s = (tail_r == '0) ? S_DONE : S_TAIL;
            S_DONE:  state_s = done_fire_s ? S_RUN : S_DONE;
            default: state_s = S_INIT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Unpacker: one byte in, four symbols out oldest first
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_r  <= 8'h00;
            left_r <= 3'd0;
        end else if (accept_s) begin
            buf_r  <= in_byte;
            left_r <= 3'd4;
        end else if (step_s) begin
            buf_r  <= {2'b00, buf_r[7:2]};
            left_r <= left_r - 3'd1;
        end
    end

    // Trellis state: metrics, survivors, symbol count and best state
    always_ff @(posedge clk) begin
        if (!rst_n || done_fire_s) begin
            for (int s = 0; s < NS; s++) begin
                pm_r[s]   <= (s == 0) ? {PM_W{1'b0}} : PM_INIT;
                surv_r[s] <= '0;
            end
            sym_cnt_r <= '0;
            best_r    <= '0;
        end else if (step_s) begin
            for (int s = 0; s < NS; s++) begin
                pm_r[s]   <= pm_next_s[s];
                surv_r[s] <= surv_next_s[s];
            end
            best_r <= best_s;
            if (!bit_due_s) begin
                sym_cnt_r <= sym_cnt_r + CW'(1);
            end
        end
    end

    // Tail counter: captures min(sym_count, D) once buffered symbols are drained
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tail_r <= '0;
        end else if ((state_r == S_FLUSH) && (left_r == 3'd0)) begin
            tail_r <= sym_cnt_r;
        end else if (tail_fire_s) begin
            tail_r <= tail_r - CW'(1);
        end
    end

    // Packer and output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pk_r         <= 8'h00;
            pk_cnt_r     <= 3'd0;
            out_byte_r   <= 8'h00;
            out_valid_r  <= 1'b0;
            flush_done_r <= 1'b0;
        end else begin
            flush_done_r <= done_fire_s;
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            if (bit_valid_s) begin
                if (pk_cnt_r == 3'd7) begin
                    out_byte_r  <= {bit_s, pk_r[6:0]};
                    out_valid_r <= 1'b1;
                    pk_r        <= 8'h00;
                    pk_cnt_r    <= 3'd0;
                end else begin
                    pk_r[pk_cnt_r] <= bit_s;
                    pk_cnt_r       <= pk_cnt_r + 3'd1;
                end
            end else if (pad_load_s) begin
                out_byte_r  <= pk_r;
                out_valid_r <= 1'b1;
                pk_r        <= 8'h00;
                pk_cnt_r    <= 3'd0;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = out_valid_r;
    assign out_byte   = out_byte_r;
    assign flush_done = flush_done_r;
endmodule

// File: tb/tb_uart_viterbi_decoder.sv
// Scoreboard bench for uart_viterbi_decoder: expected bytes queued at stimulus time,
// decoded bytes collected by a monitor and compared inside each scenario task.
module tb_uart_viterbi_decoder;
    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, out_valid, out_ready, flush, flush_done;
    logic [7:0] in_byte, out_byte;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         fd_cnt = 0;
    int         stall_viol = 0;
    logic       held_v = 1'b0;
    logic [7:0] held_b = 8'h00;
    logic       toggle_en = 1'b0;
    logic [7:0] exp_q[$], rx_q[$], msg_q[$], enc_q[$];
    logic [7:0] ff_enc [8] = '{8'hA7, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};

    uart_viterbi_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_byte    (in_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .flush      (flush),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    // Monitor: collects handshaken bytes, counts flush_done pulses, watches stall stability
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v <= 1'b0;
        end else begin
            if (held_v && ((out_valid !== 1'b1) || (out_byte !== held_b)))
                stall_viol <= stall_viol + 1;
            held_v <= out_valid && !out_ready;
            held_b <= out_byte;
            if (out_valid === 1'b1 && out_ready === 1'b1) rx_q.push_back(out_byte);
            if (flush_done === 1'b1) fd_cnt <= fd_cnt + 1;
        end
    end

    // Downstream ready: constant high, or toggling every 3 cycles when enabled
    initial begin
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (toggle_en) begin
                ph++;
                if (ph % 3 == 0) out_ready = ~out_ready;
            end else begin
                ph = 0;
                out_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Golden rate-1/2 K=3 (7,5) encoder: msg_q -> enc_q, bits LSB first, symbol j at [2j+1:2j]
    task automatic encode_msg();
        logic [1:0] st;
        logic [2:0] r;
        logic [7:0] ob;
        int j;
        st = 2'b00; ob = 8'h00; j = 0;
        enc_q.delete();
        foreach (msg_q[i]) begin
            for (int k = 0; k < 8; k++) begin
                r = {msg_q[i][k], st};
                ob[2*j+1] = ^(r & 3'b111);
                ob[2*j]   = ^(r & 3'b101);
                st = {msg_q[i][k], st[1]};
                j++;
                if (j == 4) begin
                    enc_q.push_back(ob);
                    ob = 8'h00;
                    j = 0;
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit acc;
        int n;
        acc = 1'b0; n = 0;
        in_byte = b; in_valid = 1'b1;
        while (!acc && n < 500) begin
            @(negedge clk); acc = (in_ready === 1'b1);
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic wait_idle(input int fd0);
        int n;
        n = 0;
        while (!(fd_cnt != fd0 && out_valid === 1'b0) && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_cmp++; if (out_byte !== 8'h00) begin n_fail++; $display("FAIL rst_out_byte got %h want 00", out_byte); end
        n_cmp++; if (flush_done !== 1'b0) begin n_fail++; $display("FAIL rst_flush_done got %b want 0", flush_done); end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rel_in_ready0 got %b want 0", in_ready); end
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready1 got %b want 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_ff(input string tag);
        logic [7:0] a;
        int fd0;
        fd0 = fd_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hFF);
        for (int i = 0; i < 8; i++) send_byte(ff_enc[i]);
        do_flush();
        wait_idle(fd0);
        n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL %s_flush_done got %0d want 1", tag, fd_cnt - fd0); end
        n_cmp++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL %s_count got %0d want %0d", tag, rx_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            a = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (a !== exp_q[i]) begin n_fail++; $display("FAIL %s_byte%0d got %h want %h", tag, i, a, exp_q[i]); end
        end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_no_flush();
        logic [7:0] a;
        int fd0;
        exp_q.push_back(8'h00);
        for (int i = 0; i < 5; i++) send_byte(8'h00);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL nf_early got %0d bytes want 0", rx_q.size()); end
        send_byte(8'h00);
        repeat (10) @(posedge clk);
        #1;
        n_cmp++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL nf_count got %0d want 1", rx_q.size()); end
        a = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        n_cmp++; if (a !== exp_q[0]) begin n_fail++; $display("FAIL nf_byte got %h want %h", a, exp_q[0]); end
        exp_q.delete(); rx_q.delete();
        // The 16 bits still in the decision window come out on flush
        fd0 = fd_cnt;
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        do_flush();
        wait_idle(fd0);
        n_cmp++; if (rx_q.size() != 2) begin n_fail++; $display("FAIL nf_tail_count got %0d want 2", rx_q.size()); end
        foreach (exp_q[i]) begin
            a = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (a !== exp_q[i]) begin n_fail++; $display("FAIL nf_tail%0d got %h want %h", i, a, exp_q[i]); end
        end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_error();
        logic [7:0] a;
        int fd0;
        fd0 = fd_cnt;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < 8; i++) send_byte((i == 2) ? 8'h01 : 8'h00);
        do_flush();
        wait_idle(fd0);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL err_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            a = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (a !== exp_q[i]) begin n_fail++; $display("FAIL err_byte%0d got %h want %h", i, a, exp_q[i]); end
        end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_random_stall();
        logic [7:0] a;
        int fd0, sv0;
        fd0 = fd_cnt; sv0 = stall_viol;
        msg_q.delete();
        for (int i = 0; i < 8; i++) msg_q.push_back(8'($urandom_range(0, 255)));
        encode_msg();
        foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
        toggle_en = 1'b1;
        foreach (enc_q[i]) send_byte(enc_q[i]);
        do_flush();
        wait_idle(fd0);
        toggle_en = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (stall_viol != sv0) begin n_fail++; $display("FAIL rnd_stall_stable got %0d violations want 0", stall_viol - sv0); end
        n_cmp++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", rx_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            a = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            n_cmp++; if (a !== exp_q[i]) begin n_fail++; $display("FAIL rnd_byte%0d got %h want %h", i, a, exp_q[i]); end
        end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_short_flush();
        logic [7:0] a;
        int fd0;
        fd0 = fd_cnt;
        msg_q.delete();
        msg_q.push_back(8'hB4);
        encode_msg();
        exp_q.push_back(8'hB4);
        foreach (enc_q[i]) send_byte(enc_q[i]);
        do_flush();
        wait_idle(fd0);
        n_cmp++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL short_flush_done got %0d want 1", fd_cnt - fd0); end
        n_cmp++; if (rx_q.size() != 1) begin n_fail++; $display("FAIL short_count got %0d want 1", rx_q.size()); end
        a = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        n_cmp++; if (a !== exp_q[0]) begin n_fail++; $display("FAIL short_byte got %h want %h", a, exp_q[0]); end
        exp_q.delete(); rx_q.delete();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) send_byte(ff_enc[i]);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_out_valid got %b want 0", out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_cmp++; if (rx_q.size() != 0) begin n_fail++; $display("FAIL mid_rst_stale got %0d bytes want 0", rx_q.size()); end
        rx_q.delete();
        test_ff("ff_after_rst");
    endtask

    initial begin
        test_reset();
        test_ff("ff");
        test_no_flush();
        test_error();
        test_random_stall();
        test_short_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
